// File: rtl/prim_ram_1p_adapter.sv
// Request/response adapter in front of a single-port SRAM with one read cycle of latency.
// Keeps responses in acceptance order and never accepts more requests than it can buffer responses for.
module prim_ram_1p_adapter #(
    parameter int Width    = 32,
    parameter int Depth    = 128,
    parameter int RspDepth = 2,
    localparam int Aw      = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_wmask_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_write_o,
    output logic             rsp_err_o,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i
);

    localparam int Cw = $clog2(RspDepth + 1);
    localparam int Pw = (RspDepth > 1) ? $clog2(RspDepth) : 1;

    logic [Cw-1:0]    count;
    logic [Cw-1:0]    fifo_cnt;
    logic [Pw-1:0]    rd_ptr;
    logic [Pw-1:0]    wr_ptr;
    logic             fly_valid;
    logic             fly_write;
    logic             fly_err;
    logic [Width-1:0] fly_rdata;
    logic [Width+1:0] fifo_mem [RspDepth];
    logic [Width+1:0] head;

    logic addr_err;
    logic accept;
    logic rsp_fire;
    logic fifo_empty;
    logic push;
    logic pop;

    assign addr_err    = ({1'b0, req_addr_i} >= (Aw + 1)'(Depth));
    assign req_ready_o = ~rst_i & (count < Cw'(RspDepth));
    assign accept      = req_valid_i & req_ready_o;

    assign ram_req_o   = accept & ~addr_err;
    assign ram_write_o = req_write_i;
    assign ram_addr_o  = req_addr_i;
    assign ram_wdata_o = req_wdata_i;
    assign ram_wmask_o = req_wmask_i;

    assign fly_rdata  = (fly_valid & ~fly_write & ~fly_err) ? ram_rdata_i : '0;
    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_mem[rd_ptr];

    // FIFO head has priority; otherwise the in-flight entry falls through.
    assign rsp_valid_o = ~fifo_empty | fly_valid;
    assign rsp_write_o = fifo_empty ? (fly_valid & fly_write) : head[Width+1];
    assign rsp_err_o   = fifo_empty ? (fly_valid & fly_err)   : head[Width];
    assign rsp_rdata_o = fifo_empty ? fly_rdata               : head[Width-1:0];

    assign rsp_fire = rsp_valid_o & rsp_ready_i;
    assign pop      = rsp_fire & ~fifo_empty;
    assign push     = fly_valid & ~(rsp_fire & fifo_empty);

    // Capturing ram_rdata_i on push keeps the response stable across a stall.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {fly_write, fly_err, fly_rdata};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count     <= '0;
            fifo_cnt  <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fly_valid <= 1'b0;
            fly_write <= 1'b0;
            fly_err   <= 1'b0;
        end else begin
            fly_valid <= accept;
            fly_write <= accept & req_write_i;
            fly_err   <= accept & addr_err;

            if (push) begin
                wr_ptr <= (wr_ptr == Pw'(RspDepth - 1)) ? '0 : wr_ptr + Pw'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == Pw'(RspDepth - 1)) ? '0 : rd_ptr + Pw'(1);
            end
            fifo_cnt <= fifo_cnt + Cw'(push) - Cw'(pop);

            case ({accept, rsp_fire})
                2'b10:   count <= count + Cw'(1);
                2'b01:   count <= count - Cw'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
